// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state and SPI mode types for the SPI master.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: registered half-period tick every CLK_DIV cycles while enabled, restarting on enable.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: single-word SPI master with selectable mode, bit order and chip select.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                                         clock_i,
  input  logic                                         reset_i,
  input  logic                                         start_i,
  input  logic                                         cpol_i,
  input  logic                                         cpha_i,
  input  logic [(NUM_CS > 1 ? $clog2(NUM_CS) : 1)-1:0] cs_sel_i,
  input  logic [WIDTH-1:0]                             tx_data_i,
  input  logic                                         MISO_i,
  output logic                                         SCLK_o,
  output logic                                         MOSI_o,
  output logic [NUM_CS-1:0]                            CS_n_o,
  output logic [WIDTH-1:0]                             rx_data_o,
  output logic                                         busy_o,
  output logic                                         done_o
);
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  localparam int EW  = $clog2(2 * WIDTH);
  state_t state, nxt;
  mode_t mode;
  logic [CSW-1:0] cs_q;
  logic [WIDTH-1:0] tx_sh, rx_sh;
  logic [EW-1:0] ecnt;
  logic tick, last, shift_ev;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST != 0 ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST != 0 ? w << 1 : w >> 1;
  endfunction

  function automatic logic [WIDTH-1:0] insert(input logic [WIDTH-1:0] w, input logic b);
    return MSB_FIRST != 0 ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
  endfunction

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk (clock_i),
    .rst (reset_i),
    .en  (busy_o),
    .tick(tick)
  );

  // even edge indices are leading edges; the data shifts on the edge opposite to sampling
  assign last     = ecnt == EW'(2 * WIDTH - 1);
  assign shift_ev = ~ecnt[0] == mode.cpha;

  always_ff @(posedge clock_i) state <= reset_i ? IDLE : nxt;

  always_comb begin
    nxt = state == IDLE ? (start_i ? LEAD : IDLE) :
          !tick          ? state :
          state == LEAD  ? SHIFT :
          state == SHIFT ? (last ? TRAIL : SHIFT) : IDLE;
  end

  always_comb begin
    busy_o = state != IDLE;
    for (int i = 0; i < NUM_CS; i++) CS_n_o[i] = !(busy_o && int'(cs_q) == i);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      SCLK_o    <= 1'b0;
      MOSI_o    <= 1'b0;
      done_o    <= 1'b0;
      rx_data_o <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      ecnt      <= '0;
      mode      <= '0;
      cs_q      <= '0;
    end else begin
      done_o <= state == TRAIL && tick;
      if (state == IDLE) begin
        SCLK_o <= cpol_i;
        if (start_i) begin
          mode   <= mode_t'({cpol_i, cpha_i});
          cs_q   <= cs_sel_i;
          ecnt   <= '0;
          rx_sh  <= '0;
          tx_sh  <= cpha_i ? tx_data_i : advance(tx_data_i);
          MOSI_o <= cpha_i ? 1'b0 : first_bit(tx_data_i);
        end
      end
      if (state == LEAD || state == TRAIL) SCLK_o <= mode.cpol;
      if (state == SHIFT && tick) begin
        SCLK_o <= ~SCLK_o;
        ecnt   <= ecnt + 1'b1;
        if (shift_ev) begin
          MOSI_o <= first_bit(tx_sh);
          tx_sh  <= advance(tx_sh);
        end else begin
          rx_sh <= insert(rx_sh, MISO_i);
        end
      end
      if (state == TRAIL && tick) rx_data_o <= rx_sh;
    end
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bits per transfer (legal range 2..32).
REQ-002 Parameter CLK_DIV, default 4, SHALL set the SCLK half-period in clock_i cycles (legal range >= 1).
REQ-003 Parameter NUM_CS, default 1, SHALL set the number of chip-select outputs (legal range 1..8).
REQ-004 Parameter MSB_FIRST, default 1, SHALL select bit order: 1 = MSB first, 0 = LSB first.
REQ-005 clock_i  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_i  input  1  reset, synchronous and active-high.
REQ-007 start_i  input  1  transfer request, sampled only in IDLE.
REQ-008 cpol_i  input  1  SCLK idle level.
REQ-009 cpha_i  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-010 cs_sel_i  input  max(1,$clog2(NUM_CS))  target chip-select index.
REQ-011 tx_data_i  input  WIDTH  word to transmit.
REQ-012 MISO_i  input  1  serial data from the slave.
REQ-013 SCLK_o  output  1  serial clock.
REQ-014 MOSI_o  output  1  serial data to the slave.
REQ-015 CS_n_o  output  NUM_CS  active-low chip selects.
REQ-016 rx_data_o  output  WIDTH  last received word, held until the next done_o.
REQ-017 busy_o  output  1  high in every state except IDLE.
REQ-018 done_o  output  1  one-cycle pulse at transfer completion.

Function
REQ-019 The FSM SHALL have states IDLE, LEAD, SHIFT and TRAIL.
REQ-020 IDLE: on start_i=1, latch tx_data_i, cpol_i, cpha_i and cs_sel_i, then go to LEAD on the next edge.
REQ-021 In IDLE, SCLK_o SHALL track cpol_i, registered with one cycle of delay.
REQ-022 LEAD: CS_n_o[cs_sel] low, SCLK_o = latched cpol; lasts CLK_DIV cycles; then go to SHIFT.
REQ-023 SHIFT: SCLK_o SHALL toggle every CLK_DIV cycles, giving exactly 2*WIDTH edges and WIDTH full SCLK periods; then go to TRAIL.
REQ-024 cpha=0: MOSI_o SHALL present the first bit on LEAD entry and change on each trailing edge; MISO_i SHALL be sampled on the clock edge that produces each leading SCLK edge.
REQ-025 cpha=1: MOSI_o SHALL change on each leading edge; MISO_i SHALL be sampled on the clock edge that produces each trailing SCLK edge.
REQ-026 Received bits SHALL be assembled in the order set by MSB_FIRST, matching the transmit order.
REQ-027 TRAIL: SCLK_o = cpol; lasts CLK_DIV cycles; on exit, CS_n_o goes all-high, rx_data_o updates, done_o pulses for 1 cycle, and the FSM returns to IDLE.
REQ-028 Latency: done_o SHALL assert exactly CLK_DIV*(2*WIDTH+2)+1 cycles after the edge that accepts start_i.
REQ-029 start_i asserted while busy_o=1 SHALL be ignored, with no queuing.
REQ-030 start_i may be accepted in the cycle immediately after done_o (back-to-back transfers).
REQ-031 A cs_sel value >= NUM_CS SHALL run the transfer with all CS_n_o high.
REQ-032 At most one CS_n_o bit SHALL be low at any time.
REQ-033 Changes to tx_data_i, cpol_i, cpha_i or cs_sel_i during busy_o=1 SHALL have no effect.

Reset
REQ-034 While reset_i=1, the block SHALL hold state IDLE and drive SCLK_o=0, MOSI_o=0, CS_n_o all-ones, rx_data_o=0, busy_o=0 and done_o=0.
REQ-035 reset_i asserted mid-transfer SHALL, on that same edge, abort the transfer, deassert all CS, emit no done_o and leave rx_data_o=0.

Structure
REQ-036 Package spi_pkg SHALL hold the FSM state enum and the typedef for the {cpol, cpha} mode pair.
REQ-037 Sub-module spi_clk_gen SHALL produce a one-cycle half-period tick every CLK_DIV cycles while enabled, reloading on enable.

Verification
REQ-038 WIDTH=8, CLK_DIV=2, mode 0, tx=0xA5, MISO looped to MOSI -> MOSI bit sequence 1,0,1,0,0,1,0,1; rx_data_o=0xA5; done_o 37 cycles after start.
REQ-039 Mode 3 (cpol=1, cpha=1), tx=0x3C, MISO driven with 0xC3 -> SCLK idles high; 8 rising edges; rx_data_o=0xC3.
REQ-040 start_i re-pulsed at cycle 10 of a transfer -> ignored; exactly one done_o pulse, and busy_o falls once.
REQ-041 reset_i pulsed at cycle 15 -> next edge CS_n_o=all-ones, busy_o=0, no done_o, rx_data_o=0.
REQ-042 NUM_CS=4, cs_sel=2 -> CS_n_o=4'b1011 during the transfer; cs_sel=5 (with NUM_CS=4 using a wider test bus) -> CS_n_o stays 4'b1111.
REQ-043 MSB_FIRST=0, tx=0x01 -> first MOSI bit=1; loopback gives rx=0x01; back-to-back start after done_o is accepted.
